jtag_dr_bank: RTL

- Parametrised bank of NUM_CH JTAG data registers behind one TAP; each channel is decoded from its own IR opcode.
- All channels share one shift register. A 1-bit bypass register handles every unmatched opcode.
- Each channel presents its updated value to system logic with a valid/ack handshake and a sticky overrun flag.
- Sits beside the TAP controller and IR, and replaces per-opcode single data registers.

---
 rtl/jtag_dr_bank.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: NUM_CH JTAG data registers selected by consecutive IR opcodes
// starting at OPCODE_BASE. They share one serial shift register. Any opcode
// outside that range falls through to a 1-bit bypass register.
//
// Each channel keeps the last updated payload and raises a valid flag. System
// logic clears the flag with a per-channel ack. If an update lands while the
// previous value is still unacked, the new data wins and a sticky overrun flag
// is raised.
//
// Build option JTAG_DR_BANK_STATUS_EN: widens the shift register by two bits.
// A capture then loads {overrun, valid, payload}, so a debugger can read the
// channel status from the last two shifted bits. The same capture edge clears
// that channel's overrun flag. Without the option, overrun clears only on trst
// or Test-Logic-Reset.
module jtag_dr_bank #(
  parameter int                IR_LEN      = 4,
  parameter int                DR_LEN      = 8,
  parameter int                NUM_CH      = 4,
  parameter logic [IR_LEN-1:0] OPCODE_BASE = 4'h4
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tdi,
  output logic                     tdo,
  input  logic                     state_tlr,
  input  logic                     state_capturedr,
  input  logic                     state_shiftdr,
  input  logic                     state_updatedr,
  input  logic [IR_LEN-1:0]        ir_reg,
  input  logic [NUM_CH*DR_LEN-1:0] dr_dataIn,
  output logic [NUM_CH*DR_LEN-1:0] dr_dataOut,
  output logic [NUM_CH-1:0]        dr_valid,
  input  logic [NUM_CH-1:0]        dr_ack,
  output logic [NUM_CH-1:0]        dr_overrun,
  output logic                     sel_hit
);

`ifdef JTAG_DR_BANK_STATUS_EN
  localparam int SW = DR_LEN + 2;
`else
  localparam int SW = DR_LEN;
`endif

  // Decode bounds are held as int so that OPCODE_BASE+NUM_CH == 2^IR_LEN
  // does not wrap.
  localparam int BASE_I  = int'(OPCODE_BASE);
  localparam int LIMIT_I = BASE_I + NUM_CH;

  logic [SW-1:0]            sr_q, sr_d;
  logic                     byp_q, byp_d;
  logic [NUM_CH*DR_LEN-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH-1:0]        ovr_q, ovr_d;

  int                       ir_int;
  logic                     hit;
  logic [IR_LEN-1:0]        ch_ofs;
  logic [NUM_CH-1:0]        ch_sel;
  logic [NUM_CH-1:0]        ch_upd;
  logic [DR_LEN-1:0]        cap_data;
  logic [SW-1:0]            cap_word;
  logic [SW-1:0]            sr_shift;

  // Opcode decode into a one-hot channel select.
  // The decode is recomputed every cycle, so an IR change mid-shift takes
  // effect immediately.
  always_comb begin
    ir_int = int'(ir_reg);
    hit    = (ir_int >= BASE_I) && (ir_int < LIMIT_I);
    ch_ofs = ir_reg - OPCODE_BASE;
    ch_sel = '0;
    ch_upd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = hit && (ch_ofs == IR_LEN'(i));
      ch_upd[i] = state_updatedr && ch_sel[i];
    end
  end

  // Capture value for the selected channel.
`ifdef JTAG_DR_BANK_STATUS_EN
  logic cap_valid;
  logic cap_ovr;

  // With status enabled, the selected channel's flags ride above the payload.
  always_comb begin
    cap_data  = '0;
    cap_valid = 1'b0;
    cap_ovr   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) begin
        cap_data  = dr_dataIn[i*DR_LEN +: DR_LEN];
        cap_valid = valid_q[i];
        cap_ovr   = ovr_q[i];
      end
    end
    cap_word = {cap_ovr, cap_valid, cap_data};
  end
`else
  // Without status, only the payload slice of the selected channel is captured.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) cap_data = dr_dataIn[i*DR_LEN +: DR_LEN];
    end
    cap_word = cap_data;
  end
`endif

  // Shift input: tdi enters at the MSB. A single-bit register just takes tdi.
  generate
    if (SW == 1) begin : g_shift_1
      assign sr_shift = tdi;
    end else begin : g_shift_n
      assign sr_shift = {tdi, sr_q[SW-1:1]};
    end
  endgenerate

  // Next state for the shared shift register and the bypass bit.
  // TLR overrides everything else.
  always_comb begin
    sr_d  = sr_q;
    byp_d = byp_q;
    if (state_tlr) begin
      sr_d  = '0;
      byp_d = 1'b0;
    end else if (state_capturedr) begin
      if (hit) sr_d  = cap_word;
      else     byp_d = 1'b0;
    end else if (state_shiftdr) begin
      if (hit) sr_d  = sr_shift;
      else     byp_d = tdi;
    end
  end

  // Per-channel update, ack and overrun bookkeeping.
  // Acks to non-selected channels are still honoured.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_tlr) begin
        valid_d[i] = 1'b0;
        ovr_d[i]   = 1'b0;
      end else if (ch_upd[i]) begin
        data_d[i*DR_LEN +: DR_LEN] = sr_q[DR_LEN-1:0];
        valid_d[i]                 = 1'b1;
        if (valid_q[i] && !dr_ack[i]) ovr_d[i] = 1'b1;
      end else begin
        if (dr_ack[i] && valid_q[i]) valid_d[i] = 1'b0;
`ifdef JTAG_DR_BANK_STATUS_EN
        if (state_capturedr && ch_sel[i]) ovr_d[i] = 1'b0;
`endif
      end
    end
  end

  // State registers; trst clears everything, including the held payloads.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      sr_q    <= '0;
      byp_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= '0;
      ovr_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      byp_q   <= byp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tdo        = hit ? sr_q[0] : byp_q;
  assign sel_hit    = hit;
  assign dr_dataOut = data_q;
  assign dr_valid   = valid_q;
  assign dr_overrun = ovr_q;

endmodule
